// File: rtl/hankel_mvmul.sv
// Streaming Hankel matrix-vector multiplier.
// Computes y[r] = sum_c h[r+c] * x[c] by reading operands straight from the
// sequence memory at address r+c, so the Hankel matrix is never stored.
// One result word per row leaves on a valid-qualified stream.
module hankel_mvmul #(
   parameter int ROW   = 4,
   parameter int COL   = 4,
   parameter int WIDTH = 16,
   parameter int ADDR  = 8,
   parameter int ACC_W = 2*WIDTH+$clog2(COL),
   localparam int CW   = (COL > 1) ? $clog2(COL) : 1,
   localparam int RW   = (ROW > 1) ? $clog2(ROW) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             x_we,
   input  logic [CW-1:0]    x_idx,
   input  logic [WIDTH-1:0] x_data,
   output logic [ADDR-1:0]  addr,
   output logic             rd,
   input  logic [WIDTH-1:0] data,
   output logic             y_valid,
   output logic [RW-1:0]    y_row,
   output logic [ACC_W-1:0] y_data,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [RW-1:0]            r_q, r_d;
   logic [CW-1:0]            c_q, c_d;
   logic [CW-1:0]            cprev_q, cprev_d;
   logic                     pend_q, pend_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [ADDR-1:0]          addr_q, addr_d;
   logic                     rd_q, rd_d;
   logic                     y_valid_q, y_valid_d;
   logic [RW-1:0]            y_row_q, y_row_d;
   logic [ACC_W-1:0]         y_data_q, y_data_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic signed [WIDTH-1:0]  x_q [COL];
   logic signed [WIDTH-1:0]  x_d [COL];

   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   acc_sum;

   assign addr    = addr_q;
   assign rd      = rd_q;
   assign y_valid = y_valid_q;
   assign y_row   = y_row_q;
   assign y_data  = y_data_q;
   assign busy    = busy_q;
   assign done    = done_q;

   // Multiply the word returned for last cycle's read by its column weight and fold it into the running sum.
   always_comb begin
      prod     = $signed(data) * x_q[cprev_q];
      prod_ext = ACC_W'(prod);
      acc_sum  = pend_q ? (acc_q + prod_ext) : acc_q;
   end

   // Vector register file: writes land only while the block is idle.
   always_comb begin
      for (int i = 0; i < COL; i++) begin
         x_d[i] = x_q[i];
      end
      if (state_q == S_IDLE && x_we && int'(x_idx) < COL) begin
         x_d[x_idx] = x_data;
      end
   end

   // Sequencer: walks rows and columns, issues reads at r+c and builds the registered output stream.
   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      c_d       = c_q;
      cprev_d   = c_q;
      pend_d    = rd_q;
      acc_d     = acc_sum;
      addr_d    = addr_q;
      rd_d      = 1'b0;
      y_valid_d = 1'b0;
      y_row_d   = y_row_q;
      y_data_d  = y_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            acc_d = '0;
            if (start) begin
               state_d = S_FETCH;
               r_d     = '0;
               c_d     = '0;
               rd_d    = 1'b1;
               addr_d  = '0;
               busy_d  = 1'b1;
            end
         end
         S_FETCH: begin
            if (c_q == CW'(COL-1)) begin
               state_d = S_DRAIN;
            end else begin
               c_d    = c_q + CW'(1);
               rd_d   = 1'b1;
               addr_d = ADDR'(r_q) + ADDR'(c_q) + ADDR'(1);
            end
         end
         S_DRAIN: begin
            state_d   = S_EMIT;
            y_valid_d = 1'b1;
            y_data_d  = acc_sum;
            y_row_d   = r_q;
            acc_d     = '0;
         end
         S_EMIT: begin
            if (r_q == RW'(ROW-1)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d = S_FETCH;
               r_d     = r_q + RW'(1);
               c_d     = '0;
               rd_d    = 1'b1;
               addr_d  = ADDR'(r_q) + ADDR'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, counters, accumulator and registered outputs; reset aborts any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         r_q       <= '0;
         c_q       <= '0;
         cprev_q   <= '0;
         pend_q    <= 1'b0;
         acc_q     <= '0;
         addr_q    <= '0;
         rd_q      <= 1'b0;
         y_valid_q <= 1'b0;
         y_row_q   <= '0;
         y_data_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         c_q       <= c_d;
         cprev_q   <= cprev_d;
         pend_q    <= pend_d;
         acc_q     <= acc_d;
         addr_q    <= addr_d;
         rd_q      <= rd_d;
         y_valid_q <= y_valid_d;
         y_row_q   <= y_row_d;
         y_data_q  <= y_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Vector registers keep their values across runs and clear only on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < COL; i++) begin
            x_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < COL; i++) begin
            x_q[i] <= x_d[i];
         end
      end
   end

endmodule

// File: tb/tb_hankel_mvmul.sv
// Directed testbench for hankel_mvmul (4x4, 16-bit) with a 1-cycle-latency sequence memory model.
module tb_hankel_mvmul;

   localparam int ROW   = 4;
   localparam int COL   = 4;
   localparam int WIDTH = 16;
   localparam int ADDR  = 8;
   localparam int ACC_W = 2*WIDTH+$clog2(COL);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             x_we = 1'b0;
   logic [1:0]       x_idx = '0;
   logic [WIDTH-1:0] x_data = '0;
   logic [ADDR-1:0]  addr;
   logic             rd;
   logic [WIDTH-1:0] data = '0;
   logic             y_valid;
   logic [1:0]       y_row;
   logic [ACC_W-1:0] y_data;
   logic             busy;
   logic             done;

   logic [WIDTH-1:0] mem [16];

   int errors = 0;
   int checks = 0;

   longint yv[$];
   int     yr[$];
   int     yc[$];
   int     ad[$];
   int     rc[$];
   int     dc[$];

   hankel_mvmul #(
      .ROW(ROW), .COL(COL), .WIDTH(WIDTH), .ADDR(ADDR), .ACC_W(ACC_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .x_we(x_we), .x_idx(x_idx),
      .x_data(x_data), .addr(addr), .rd(rd), .data(data), .y_valid(y_valid),
      .y_row(y_row), .y_data(y_data), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Sequence memory: returns the addressed word one cycle after the read strobe.
   always @(posedge clk) begin
      if (rd) data <= mem[addr[3:0]];
   end

   task automatic checkOutput(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic loadH(input bit ramp, input int val);
      for (int i = 0; i < 16; i++) mem[i] = ramp ? WIDTH'(i+1) : WIDTH'(val);
   endtask

   task automatic loadX(input int a, input int b, input int c, input int d);
      int v[4];
      v = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         x_we = 1'b1; x_idx = 2'(i); x_data = v[i][WIDTH-1:0];
      end
      @(negedge clk);
      x_we = 1'b0;
   endtask

   // Launch a run and record everything the DUT emits, cycle-indexed from the start-sampling edge.
   task automatic applyStimulus(input bit holdStart, input int injectAt, input int resetAt);
      int n;
      bit fin;
      yv.delete(); yr.delete(); yc.delete(); ad.delete(); rc.delete(); dc.delete();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!holdStart) start = 1'b0;
      n = 0;
      fin = 1'b0;
      while (!fin && n < 150) begin
         @(negedge clk);
         n++;
         if (rd) begin ad.push_back(int'(addr)); rc.push_back(n); end
         if (y_valid) begin
            yv.push_back(longint'($signed(y_data)));
            yr.push_back(int'(y_row));
            yc.push_back(n);
         end
         if (done) begin
            dc.push_back(n);
            if (!holdStart || dc.size() == 2) begin
               start = 1'b0;
               fin = 1'b1;
            end
         end
         if (n == injectAt) begin
            start = 1'b1; x_we = 1'b1; x_idx = 2'd0; x_data = 16'd5;
         end else if (n == injectAt + 1) begin
            start = 1'b0; x_we = 1'b0;
         end
         if (n == resetAt) begin
            rst_n = 1'b0;
            #1;
            checkOutput("rstmid_addr", longint'(addr), 0);
            checkOutput("rstmid_rd", longint'(rd), 0);
            checkOutput("rstmid_busy", longint'(busy), 0);
            checkOutput("rstmid_yvalid", longint'(y_valid), 0);
            checkOutput("rstmid_ydata", longint'(y_data), 0);
            fin = 1'b1;
         end
      end
      if (!fin) checkOutput("run_timeout", longint'(n), 0);
   endtask

   task automatic checkResults(input string tag, input longint e0, input longint e1,
                               input longint e2, input longint e3);
      longint e[4];
      e = '{e0, e1, e2, e3};
      checkOutput({tag, "_ycount"}, longint'(yv.size()), 4);
      checkOutput({tag, "_donecount"}, longint'(dc.size()), 1);
      if (dc.size() > 0) checkOutput({tag, "_donecycle"}, longint'(dc[0]), 25);
      for (int i = 0; i < 4 && i < yv.size(); i++) begin
         checkOutput($sformatf("%s_y%0d", tag, i), yv[i], e[i]);
         checkOutput($sformatf("%s_row%0d", tag, i), longint'(yr[i]), longint'(i));
         checkOutput($sformatf("%s_ycyc%0d", tag, i), longint'(yc[i]), longint'(6*(i+1)));
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset_addr", longint'(addr), 0);
      checkOutput("reset_rd", longint'(rd), 0);
      checkOutput("reset_busy", longint'(busy), 0);
      checkOutput("reset_done", longint'(done), 0);
      checkOutput("reset_yvalid", longint'(y_valid), 0);
      checkOutput("reset_ydata", longint'(y_data), 0);
      checkOutput("reset_yrow", longint'(y_row), 0);
      rst_n = 1'b1;

      // Column select with address trace
      loadH(1'b1, 0);
      loadX(1, 0, 0, 0);
      applyStimulus(1'b0, -1, -1);
      checkResults("colsel", 1, 2, 3, 4);
      checkOutput("colsel_addrcount", longint'(ad.size()), 16);
      for (int k = 0; k < 16 && k < ad.size(); k++)
         checkOutput($sformatf("colsel_addr%0d", k), longint'(ad[k]), longint'(k/4 + k%4));

      // All-ones vector
      loadX(1, 1, 1, 1);
      applyStimulus(1'b0, -1, -1);
      checkResults("ones", 10, 14, 18, 22);

      // Signed extremes
      loadH(1'b0, 32'h7FFF);
      loadX(-1, -1, -1, -1);
      applyStimulus(1'b0, -1, -1);
      checkResults("maxneg", -131068, -131068, -131068, -131068);
      loadH(1'b0, 32'h8000);
      loadX(32'h8000, 32'h8000, 32'h8000, 32'h8000);
      applyStimulus(1'b0, -1, -1);
      checkResults("minmin", 64'd4294967296, 64'd4294967296, 64'd4294967296, 64'd4294967296);

      // start and x_we pulsed mid-run are ignored; the write is not applied later
      loadH(1'b1, 0);
      loadX(1, 1, 1, 1);
      applyStimulus(1'b0, 8, -1);
      checkResults("busyctl", 10, 14, 18, 22);
      applyStimulus(1'b0, -1, -1);
      checkResults("busyctl_after", 10, 14, 18, 22);

      // Reset during row 2 fetch
      applyStimulus(1'b0, -1, 14);
      checkOutput("rstmid_rows_before", longint'(yv.size()), 2);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rstmid_idle_busy", longint'(busy), 0);
      checkOutput("rstmid_idle_rd", longint'(rd), 0);
      applyStimulus(1'b0, -1, -1);
      checkResults("rstmid_xcleared", 0, 0, 0, 0);
      loadX(1, 1, 1, 1);
      applyStimulus(1'b0, -1, -1);
      checkResults("rstmid_reload", 10, 14, 18, 22);

      // Back-to-back runs with start held high
      applyStimulus(1'b1, -1, -1);
      checkOutput("b2b_donecount", longint'(dc.size()), 2);
      if (dc.size() == 2) begin
         checkOutput("b2b_done0", longint'(dc[0]), 25);
         checkOutput("b2b_done1", longint'(dc[1]), 51);
      end
      checkOutput("b2b_rdcount", longint'(rc.size()), 32);
      if (rc.size() > 16) checkOutput("b2b_run2_first_rd", longint'(rc[16]), 27);
      checkOutput("b2b_ycount", longint'(yv.size()), 8);
      for (int i = 0; i < 8 && i < yv.size(); i++)
         checkOutput($sformatf("b2b_y%0d", i), yv[i], longint'(10 + 4*(i%4)));
      repeat (4) @(negedge clk);
      checkOutput("b2b_stopped_busy", longint'(busy), 0);
      checkOutput("b2b_stopped_done", longint'(done), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
